// File: rtl/mem_timer_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_timer_responder
// Purpose  : Memory-mapped 32-bit prescaled timer on the responder side of the
//            merged memory bus. Single-word rd/wr/ready handshake with byte
//            lane writes, compare match, overflow and level interrupt.
// Options  : TIMER_CAPTURE_EN - adds the capture_i input, the CAPTURE register
//            and STATUS[2]. When undefined, CAPTURE/STATUS[2] read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timer_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  byte_select_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_data_o,
`ifdef TIMER_CAPTURE_EN
    input  logic        capture_i,
`endif
    output logic        irq_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_OFF_CTRL    = 3'd0;
    localparam logic [2:0] c_OFF_COUNT   = 3'd1;
    localparam logic [2:0] c_OFF_COMPARE = 3'd2;
    localparam logic [2:0] c_OFF_STATUS  = 3'd3;
    localparam logic [2:0] c_OFF_PRESC   = 3'd4;
    localparam logic [2:0] c_OFF_CAPTURE = 3'd5;

    // WAIT is entered with the remaining extra cycles minus one, so the
    // state spends exactly WAIT_CYCLES cycles there.
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Bus-side state
    // ------------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        ready_q;
    logic        op_wr_q;
    logic [2:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // ------------------------------------------------------------------------
    // Timer registers and next-state values
    // ------------------------------------------------------------------------
    logic [2:0]  ctrl_q,      ctrl_d;
    logic [31:0] count_q,     count_d;
    logic [31:0] compare_q,   compare_d;
    logic [2:0]  status_q,    status_d;
    logic [31:0] presc_q,     presc_d;
    logic [31:0] presc_cnt_q, presc_cnt_d;
    logic        irq_q,       irq_d;

    logic        w_hit;
    logic        w_req;
    logic        w_commit;
    logic        w_wr_count;
    logic        w_wr_presc;
    logic        w_tick;
    logic        w_match;
    logic        w_cap_rise;
    logic [2:0]  w_set;
    logic [2:0]  w_clr;
    logic [31:0] w_rdata;
    logic        unused_addr_lsb;

`ifdef TIMER_CAPTURE_EN
    logic [31:0] capture_q, capture_d;
    logic [2:0]  cap_sync_q;
`endif

    // Byte-lane merge: lane n takes new data when its enable is set.
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                res[8*n +: 8] = new_v[8*n +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_hit           = (mem_addr_i[31:5] == BASE_ADDR[31:5]);
    assign w_req           = w_hit && (mem_rd_i || mem_wr_i);
    assign unused_addr_lsb = ^mem_addr_i[1:0];

    // Bus handshake FSM: latch the request, optional wait, one-cycle ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            ready_q    <= 1'b0;
            op_wr_q    <= 1'b0;
            addr_q     <= 3'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (w_req) begin
                        addr_q  <= mem_addr_i[4:2];
                        wdata_q <= mem_data_i;
                        be_q    <= byte_select_i;
                        // Simultaneous rd and wr is handled as a write.
                        op_wr_q <= mem_wr_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q    <= S_WAIT;
                            wait_cnt_q <= c_WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // A write takes effect at the edge that ends the ready cycle.
    assign w_commit   = ready_q && op_wr_q;
    assign w_wr_count = w_commit && (addr_q == c_OFF_COUNT) && (be_q != 4'd0);
    assign w_wr_presc = w_commit && (addr_q == c_OFF_PRESC) && (be_q != 4'd0);

    // Prescaler reaching PRESC produces a timer tick.
    assign w_tick  = ctrl_q[0] && (presc_cnt_q == presc_q);
    assign w_match = (count_q == compare_q);

`ifdef TIMER_CAPTURE_EN
    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_sync_q <= 3'd0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], capture_i};
        end
    end
    assign w_cap_rise = cap_sync_q[1] & ~cap_sync_q[2];
`else
    assign w_cap_rise = 1'b0;
`endif

    // Read mux sampled in the ready cycle itself.
    always_comb begin
        w_rdata = 32'd0;
        case (addr_q)
            c_OFF_CTRL:    w_rdata = {29'd0, ctrl_q};
            c_OFF_COUNT:   w_rdata = count_q;
            c_OFF_COMPARE: w_rdata = compare_q;
            c_OFF_STATUS:  w_rdata = {29'd0, status_q};
            c_OFF_PRESC:   w_rdata = presc_q;
`ifdef TIMER_CAPTURE_EN
            c_OFF_CAPTURE: w_rdata = capture_q;
`endif
            default:       w_rdata = 32'd0;
        endcase
    end

    assign mem_ready_o = ready_q;
    assign mem_data_o  = (ready_q && !op_wr_q) ? w_rdata : 32'd0;
    assign irq_o       = irq_q;

    // Timer, register write and status next-state logic.
    always_comb begin
        ctrl_d      = ctrl_q;
        count_d     = count_q;
        compare_d   = compare_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        w_set       = 3'd0;
        w_clr       = 3'd0;
`ifdef TIMER_CAPTURE_EN
        capture_d   = capture_q;
`endif

        // A bus write to COUNT or PRESC restarts the prescale period.
        if (w_wr_count || w_wr_presc) begin
            presc_cnt_d = 32'd0;
        end else if (ctrl_q[0]) begin
            presc_cnt_d = w_tick ? 32'd0 : presc_cnt_q + 32'd1;
        end

        // COUNT: bus write beats a tick; a colliding tick is dropped entirely.
        if (w_wr_count) begin
            count_d = f_merge(count_q, wdata_q, be_q);
        end else if (w_tick && !w_wr_presc) begin
            w_set[0] = w_match;
            if (w_match && ctrl_q[2]) begin
                count_d = 32'd0;
            end else begin
                count_d  = count_q + 32'd1;
                w_set[1] = &count_q;
            end
        end

        if (w_commit && (addr_q == c_OFF_CTRL) && be_q[0]) begin
            ctrl_d = wdata_q[2:0];
        end
        if (w_commit && (addr_q == c_OFF_COMPARE)) begin
            compare_d = f_merge(compare_q, wdata_q, be_q);
        end
        if (w_wr_presc) begin
            presc_d = f_merge(presc_q, wdata_q, be_q);
        end
        if (w_commit && (addr_q == c_OFF_STATUS) && be_q[0]) begin
            w_clr = wdata_q[2:0];
        end

`ifdef TIMER_CAPTURE_EN
        w_set[2] = w_cap_rise;
        if (w_cap_rise) begin
            capture_d = count_q;
        end else if (w_commit && (addr_q == c_OFF_CAPTURE)) begin
            capture_d = f_merge(capture_q, wdata_q, be_q);
        end
`else
        w_clr[2] = 1'b0;
`endif

        // Hardware set takes priority over write-1-to-clear.
        status_d = (status_q & ~w_clr) | w_set;
        irq_d    = (|status_d) & ctrl_d[1];
    end

    // Timer register state; reset also discards any pending bus write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q      <= 3'd0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            status_q    <= 3'd0;
            presc_q     <= 32'd0;
            presc_cnt_q <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            irq_q       <= irq_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    // Capture register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            capture_q <= 32'd0;
        end else begin
            capture_q <= capture_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_timer_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_timer_responder
// Purpose  : Self-checking bench for mem_timer_responder (table of bus
//            vectors plus hand-written timer, miss, capture and reset cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_timer_responder;

    localparam logic [31:0] B0 = 32'h0002_0000;
    localparam logic [31:0] B3 = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  be;
    logic        capture;
    logic        ready0, ready3, irq0, irq3;
    logic [31:0] data0, data3;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mem_timer_responder #(.BASE_ADDR(B0), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_addr_i(mem_addr), .mem_data_i(mem_wdata), .byte_select_i(be),
        .mem_ready_o(ready0), .mem_data_o(data0),
`ifdef TIMER_CAPTURE_EN
        .capture_i(capture),
`endif
        .irq_o(irq0));

    mem_timer_responder #(.BASE_ADDR(B3), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
        .mem_addr_i(mem_addr), .mem_data_i(mem_wdata), .byte_select_i(be),
        .mem_ready_o(ready3), .mem_data_o(data3),
`ifdef TIMER_CAPTURE_EN
        .capture_i(1'b0),
`endif
        .irq_o(irq3));

    typedef struct {
        int          op;    // 0 read, 1 write, 2 read+write
        logic [7:0]  off;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus access. exp_lat < 0 means no block may respond.
    task automatic access(input int sel, input int op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] bsel,
                          input logic [31:0] exp_rd, input int exp_lat, input string nm);
        int n;
        bit seen;
        bit idle_ok;
        logic [31:0] exp_v;
        @(posedge clk); #1;
        mem_rd    = (op != 1);
        mem_wr    = (op != 0);
        mem_addr  = addr;
        mem_wdata = data;
        be        = bsel;
        if (exp_lat >= 0) sb_q.push_back((op == 0) ? exp_rd : 32'h0);
        seen = 0; idle_ok = 1; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (exp_lat < 0) begin
                if (ready0 || ready3) seen = 1;
            end else if ((sel == 0) ? ready0 : ready3) begin
                seen = 1;
                chk({nm, "_lat"}, n, exp_lat);
                if (sb_q.size() == 0) begin
                    chk({nm, "_sb_empty"}, 1, 0);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk({nm, "_data"}, (sel == 0) ? data0 : data3, exp_v);
                end
            end else if (((sel == 0) ? data0 : data3) != 32'h0) begin
                idle_ok = 0;
            end
        end
        mem_rd = 0;
        mem_wr = 0;
        if (exp_lat < 0) begin
            chk({nm, "_no_ready"}, seen, 0);
        end else begin
            if (!seen) begin
                chk({nm, "_timeout"}, 0, 1);
                sb_q.delete();
            end
            chk({nm, "_idle_data"}, idle_ok, 1);
        end
    endtask

    initial begin
        logic [31:0] exp_cnt[10];
        bit          rst_ok;
`ifdef TIMER_CAPTURE_EN
        logic [31:0] cap;
`endif
        exp_cnt = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0, 32'd0};

        vt[0]  = '{0, 8'h00, 32'h0,          4'hF, 32'h0};
        vt[1]  = '{0, 8'h04, 32'h0,          4'hF, 32'h0};
        vt[2]  = '{0, 8'h0C, 32'h0,          4'hF, 32'h0};
        vt[3]  = '{1, 8'h08, 32'h0000_0005,  4'hF, 32'h0};
        vt[4]  = '{0, 8'h08, 32'h0,          4'hF, 32'h0000_0005};
        vt[5]  = '{1, 8'h08, 32'h1122_3344,  4'hF, 32'h0};
        vt[6]  = '{1, 8'h08, 32'hAABB_CCDD,  4'b0010, 32'h0};
        vt[7]  = '{0, 8'h08, 32'h0,          4'hF, 32'h1122_CC44};
        vt[8]  = '{1, 8'h08, 32'hFFFF_FFFF,  4'h0, 32'h0};
        vt[9]  = '{0, 8'h08, 32'h0,          4'hF, 32'h1122_CC44};
        vt[10] = '{1, 8'h1C, 32'hFFFF_FFFF,  4'hF, 32'h0};
        vt[11] = '{0, 8'h1C, 32'h0,          4'hF, 32'h0};
        vt[12] = '{1, 8'h14, 32'h0000_1234,  4'hF, 32'h0};
`ifdef TIMER_CAPTURE_EN
        vt[13] = '{0, 8'h14, 32'h0,          4'hF, 32'h0000_1234};
`else
        vt[13] = '{0, 8'h14, 32'h0,          4'hF, 32'h0};
`endif
        vt[14] = '{2, 8'h10, 32'h0000_0007,  4'hF, 32'h0};
        vt[15] = '{0, 8'h10, 32'h0,          4'hF, 32'h0000_0007};
        vt[16] = '{1, 8'h10, 32'h0,          4'hF, 32'h0};
        vt[17] = '{0, 8'h18, 32'h0,          4'hF, 32'h0};

        rst = 1; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; be = 0; capture = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("rst_ready0", ready0, 0);
        chk("rst_data0",  data0,  0);
        chk("rst_irq0",   irq0,   0);
        chk("rst_ready3", ready3, 0);
        chk("rst_irq3",   irq3,   0);

        // Register access vectors on the zero-wait block.
        for (int i = 0; i < 18; i++) begin
            access(0, vt[i].op, B0 + {24'h0, vt[i].off}, vt[i].data, vt[i].be,
                   vt[i].exp, 1, $sformatf("vec%0d", i));
        end

        // Three-wait-cycle block.
        access(1, 0, B3 + 32'h00, 32'h0, 4'hF, 32'h0, 4, "w3_ctrl");
        access(1, 1, B3 + 32'h08, 32'hCAFE_0001, 4'hF, 32'h0, 4, "w3_wcmp");
        access(1, 0, B3 + 32'h08, 32'h0, 4'hF, 32'hCAFE_0001, 4, "w3_rcmp");

        // Prescaled count with compare match and auto-reload.
        access(0, 1, B0 + 32'h08, 32'd3, 4'hF, 32'h0, 1, "t1_cmp");
        access(0, 1, B0 + 32'h10, 32'd1, 4'hF, 32'h0, 1, "t1_presc");
        access(0, 1, B0 + 32'h04, 32'd0, 4'hF, 32'h0, 1, "t1_count");
        access(0, 1, B0 + 32'h00, 32'd7, 4'hF, 32'h0, 1, "t1_ctrl");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t1_cnt%0d", i), u_dut0.count_q, exp_cnt[i]);
            chk($sformatf("t1_irq%0d", i), irq0, (i >= 8) ? 32'd1 : 32'd0);
        end
        access(0, 1, B0 + 32'h00, 32'd6, 4'hF, 32'h0, 1, "t1_stop");
        access(0, 1, B0 + 32'h0C, 32'd1, 4'h1, 32'h0, 1, "t1_w1c");
        @(posedge clk); #1;
        chk("t1_irq_clr", irq0, 0);
        access(0, 0, B0 + 32'h0C, 32'h0, 4'hF, 32'h0, 1, "t1_status");

        // Overflow wrap.
        access(0, 1, B0 + 32'h08, 32'h100, 4'hF, 32'h0, 1, "t2_cmp");
        access(0, 1, B0 + 32'h10, 32'h0, 4'hF, 32'h0, 1, "t2_presc");
        access(0, 1, B0 + 32'h04, 32'hFFFF_FFFE, 4'hF, 32'h0, 1, "t2_count");
        access(0, 1, B0 + 32'h00, 32'd1, 4'hF, 32'h0, 1, "t2_ctrl");
        @(posedge clk); #1; chk("t2_c1", u_dut0.count_q, 32'hFFFF_FFFE);
        @(posedge clk); #1; chk("t2_c2", u_dut0.count_q, 32'hFFFF_FFFF);
        @(posedge clk); #1; chk("t2_c3", u_dut0.count_q, 32'h0);
        access(0, 1, B0 + 32'h00, 32'd0, 4'hF, 32'h0, 1, "t2_stop");
        access(0, 0, B0 + 32'h0C, 32'h0, 4'hF, 32'h2, 1, "t2_status");
        chk("t2_irq", irq0, 0);

        // Out-of-range address: nobody answers.
        access(0, 0, B0 + 32'h40, 32'h0, 4'hF, 32'h0, -1, "miss");

`ifdef TIMER_CAPTURE_EN
        access(0, 1, B0 + 32'h04, 32'd100, 4'hF, 32'h0, 1, "cap_count");
        access(0, 1, B0 + 32'h00, 32'd1, 4'hF, 32'h0, 1, "cap_ctrl");
        @(posedge clk); #1;
        chk("cap_pre", u_dut0.count_q, 32'd100);
        capture = 1;
        @(posedge clk); #1;
        capture = 0;
        repeat (4) @(posedge clk);
        #1;
        cap = u_dut0.capture_q;
        chk("cap_val", (cap >= 32'd101 && cap <= 32'd103) ? 32'd1 : 32'd0, 32'd1);
        access(0, 1, B0 + 32'h00, 32'd0, 4'hF, 32'h0, 1, "cap_stop");
        access(0, 0, B0 + 32'h0C, 32'h0, 4'hF, 32'h6, 1, "cap_status");
`endif

        // Reset in the middle of a waiting transaction aborts it.
        @(posedge clk); #1;
        mem_wr = 1; mem_addr = B3 + 32'h08; mem_wdata = 32'hDEAD; be = 4'hF;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst_ok = (ready3 == 0);
        mem_wr = 0;
        rst = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready3) rst_ok = 0;
        end
        chk("abort_no_ready", rst_ok, 1);
        access(1, 0, B3 + 32'h08, 32'h0, 4'hF, 32'h0, 4, "abort_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
